// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, status-flag bundle and shift-width helper shared by alu_pipe.
// The MUL encoding is only executed when ALU_PIPE_MUL_EN is defined.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        SLT = 4'd5,
        SLL = 4'd6,
        SRL = 4'd7,
        MUL = 4'd8
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

    // Only the low log2(width) bits of operand B steer a shift.
    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational result and flag computation feeding the first pipe stage.
// The multiplier is only built when ALU_PIPE_MUL_EN is defined; otherwise MUL is an undefined opcode.
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ALU_OP_W-1:0] i_op,
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    output logic [WIDTH-1:0]    o_c,
    output alu_flags_t          o_flags
);

    localparam int SHW = shamt_width(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_c;
    logic             w_carry;
    logic             w_ovf;

    // The extra top bit of the difference is the unsigned borrow.
    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_shamt = i_b[SHW-1:0];

`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
`endif

    always_comb begin
        w_c     = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (alu_op_e'(i_op))
            ADD: begin
                w_c     = w_sum[MSB:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            SUB: begin
                w_c     = w_diff[MSB:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            AND: w_c = i_a & i_b;
            OR:  w_c = i_a | i_b;
            XOR: w_c = i_a ^ i_b;
            SLT: w_c = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            SLL: w_c = i_a << w_shamt;
            SRL: w_c = i_a >> w_shamt;
`ifdef ALU_PIPE_MUL_EN
            MUL: begin
                w_c   = w_prod[MSB:0];
                w_ovf = |w_prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
    end

    assign o_c           = w_c;
    assign o_flags.zero  = (w_c == '0);
    assign o_flags.carry = w_carry;
    assign o_flags.ovf   = w_ovf;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: LATENCY-stage pipelined ALU with valid/ready on both sides; the whole pipe stalls as one unit.
// Define ALU_PIPE_MUL_EN to enable the MUL opcode (requires LATENCY >= 2).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    output logic                ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    c,
    output logic                zero,
    output logic                carry,
    output logic                ovf
);

    if (WIDTH < 8) begin : g_bad_width
        $error("alu_pipe: WIDTH must be at least 8");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("alu_pipe: LATENCY must be at least 1");
    end
`ifdef ALU_PIPE_MUL_EN
    if (LATENCY < 2) begin : g_bad_mul_latency
        $error("alu_pipe: MUL needs LATENCY of at least 2");
    end
`endif

    logic             w_adv;
    logic [WIDTH-1:0] w_c;
    alu_flags_t       w_flags;

    logic             r_vld   [LATENCY];
    logic [WIDTH-1:0] r_c     [LATENCY];
    alu_flags_t       r_flags [LATENCY];

    alu_pipe_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_c     (w_c),
        .o_flags (w_flags)
    );

    assign w_adv = !out_valid || out_ready;
    assign ready = w_adv;

    // Bubbles move only the valid bit so payload registers toggle only for real beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_vld[s]   <= 1'b0;
                r_c[s]     <= '0;
                r_flags[s] <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= valid;
            if (valid) begin
                r_c[0]     <= w_c;
                r_flags[0] <= w_flags;
            end
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_c[s]     <= r_c[s-1];
                    r_flags[s] <= r_flags[s-1];
                end
            end
        end
    end

    assign out_valid = r_vld[LATENCY-1];
    assign c         = r_c[LATENCY-1];
    assign zero      = r_flags[LATENCY-1].zero;
    assign carry     = r_flags[LATENCY-1].carry;
    assign ovf       = r_flags[LATENCY-1].ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=32, LATENCY=2) with an arithmetic reference model.
// Directed corner cases are followed by randomized beats under random downstream backpressure.
module tb_alu_pipe;
   import alu_pkg::*;

   typedef struct packed {
      logic [31:0] c;
      logic        zero;
      logic        carry;
      logic        ovf;
   } exp_t;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        valid = 1'b0;
   logic        ready;
   logic [3:0]  op = 4'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] c;
   logic        zero;
   logic        carry;
   logic        ovf;

   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];
   exp_t monExp;
   bit   rndDone;

   alu_pipe #(
      .WIDTH   (32),
      .LATENCY (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .ready     (ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .zero      (zero),
      .carry     (carry),
      .ovf       (ovf)
   );

   // 10 ns clock; inputs change on the falling edge, outputs are sampled just after it
   always #5 clk = ~clk;

   // Reference model written from the arithmetic definition of each opcode using 64-bit math
   function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      longint      sx;
      longint      sy;
      longint      r;
      logic [63:0] u;
      e  = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         4'd0: begin
            u       = 64'(x) + 64'(y);
            e.c     = u[31:0];
            e.carry = u[32];
            r       = sx + sy;
            e.ovf   = (r > SMAX) || (r < SMIN);
         end
         4'd1: begin
            e.c     = x - y;
            e.carry = (x < y);
            r       = sx - sy;
            e.ovf   = (r > SMAX) || (r < SMIN);
         end
         4'd2: e.c = x & y;
         4'd3: e.c = x | y;
         4'd4: e.c = x ^ y;
         4'd5: e.c = (sx < sy) ? 32'd1 : 32'd0;
         4'd6: e.c = x << (y % 32);
         4'd7: e.c = x >> (y % 32);
`ifdef ALU_PIPE_MUL_EN
         4'd8: begin
            u     = 64'(x) * 64'(y);
            e.c   = u[31:0];
            e.ovf = (u[63:32] != 0);
         end
`endif
         default: e.c = 32'd0;
      endcase
      e.zero = (e.c == 32'd0);
      return e;
   endfunction

   // Every comparison funnels through here so the counters are stepped in one place
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Hold one beat on the input until it is accepted, then record its expected result
   task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      int n;
      n = 0;
      @(negedge clk);
      valid = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      #1;
      while (!ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!ready) checkOutput("accept_timeout", 64'(ready), 64'd1);
      else expQ.push_back(model(o, x, y));
   endtask

   task automatic idleInput();
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
   endtask

   task automatic applyReset();
      @(negedge clk);
      valid = 1'b0;
      reset = 1'b0;
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_c", 64'(c), 64'd0);
      checkOutput("rst_flags", 64'({zero, carry, ovf}), 64'd0);
      checkOutput("rst_ready", 64'(ready), 64'd1);
      expQ.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Monitor: pops and compares whenever the DUT completes an output handshake
   always begin
      @(negedge clk);
      #2;
      if (reset && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", 64'(c), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("beat", 64'({c, zero, carry, ovf}), 64'(monExp));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      rndDone = 1'b0;
      applyReset();

      // ADD carry-out with exact latency check
      out_ready = 1'b1;
      applyStimulus(4'(ADD), 32'hFFFF_FFFF, 32'd1);
      idleInput();
      #1;
      checkOutput("latency_1", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      checkOutput("latency_2", 64'(out_valid), 64'd1);
      drain();

      // SUB overflow and SLT signed compare
      applyStimulus(4'(SUB), 32'h8000_0000, 32'd1);
      applyStimulus(4'(SLT), 32'hFFFF_FFFE, 32'd1);
      idleInput();
      drain();

      // Stream of 8 beats with a 3-cycle downstream stall on the first result
      fork
         begin
            for (int i = 0; i < 8; i++) applyStimulus(4'(ADD), 32'(i), 32'(i));
            idleInput();
         end
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_valid && n < 20);
            checkOutput("stall_seen_valid", 64'(out_valid), 64'd1);
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               #1;
               checkOutput("stall_ready", 64'(ready), 64'd0);
               checkOutput("stall_hold", 64'({out_valid, c}), 64'({1'b1, 32'd0}));
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      repeat (3) @(negedge clk);
      #1;
      checkOutput("stream_idle", 64'(out_valid), 64'd0);

      // Shifts with masked shift amount, undefined opcode, MUL encoding
      applyStimulus(4'(SLL), 32'd1, 32'h0000_0025);
      applyStimulus(4'(SRL), 32'h8000_0000, 32'd31);
      applyStimulus(4'hF, 32'd5, 32'd5);
      applyStimulus(4'(MUL), 32'h0001_0000, 32'h0001_0000);
      idleInput();
      drain();

      // Reset with two beats stalled in flight
      out_ready = 1'b0;
      applyStimulus(4'(ADD), 32'd10, 32'd20);
      applyStimulus(4'(XOR), 32'hA5A5_A5A5, 32'hFFFF_0000);
      idleInput();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst_c", 64'(c), 64'd0);
      expQ.delete();
      repeat (2) @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      applyStimulus(4'(ADD), 32'd3, 32'd4);
      idleInput();
      drain();
      repeat (4) @(negedge clk);
      #1;
      checkOutput("midrst_no_stale", 64'(out_valid), 64'd0);

      // Randomized beats with random backpressure
      fork
         begin
            logic [31:0] x;
            logic [31:0] y;
            for (int i = 0; i < 200; i++) begin
               case ($urandom_range(0, 3))
                  0:       x = $urandom;
                  1:       x = 32'h8000_0000;
                  2:       x = 32'hFFFF_FFFF;
                  default: x = 32'($urandom_range(0, 40));
               endcase
               case ($urandom_range(0, 3))
                  0:       y = $urandom;
                  1:       y = 32'h7FFF_FFFF;
                  2:       y = 32'd1;
                  default: y = 32'($urandom_range(0, 40));
               endcase
               applyStimulus(4'($urandom_range(0, 15)), x, y);
               if ($urandom_range(0, 4) == 0) idleInput();
            end
            idleInput();
            rndDone = 1'b1;
         end
         begin
            int cyc;
            cyc = 0;
            while (!rndDone && cyc < 5000) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
               cyc++;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
